// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: selects sequential or predicted next PC, tracks in-flight control-flow
// predictions in an in-order FIFO, and redirects fetch with a one-cycle flush on a mispredict.
module fetch_redirect_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_resp,
  input  logic        stall,
  input  logic        br_instr,
  input  logic        prediction_valid,
  input  logic        predicted_direction,
  input  logic [15:0] predicted_target,
  input  logic        res_valid,
  input  logic [15:0] res_pc,
  input  logic        res_direction,
  input  logic [15:0] res_target,
  output logic [15:0] pc_out,
  output logic        imem_read,
  output logic        flush,
  output logic        q_full,
  output logic        q_err,
  output logic [15:0] mispredict_count
);

  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [0:0] ST_FETCH   = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [0:0]    state_r, state_nx_s;
  logic [15:0]   pc_r;
  logic [15:0]   mp_cnt_r;
  logic          q_err_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic [15:0]   q_pc_r    [DEPTH];
  logic          q_taken_r [DEPTH];
  logic [15:0]   q_tgt_r   [DEPTH];

  logic empty_s, full_s, fetch_st_s, pred_taken_s;
  logic tag_err_s, mispredict_s, pop_s, accept_s, push_s;

  assign empty_s      = (count_r == {(AW+1){1'b0}});
  assign full_s       = (count_r == FULL_CNT);
  assign fetch_st_s   = (state_r == ST_FETCH);
  assign pred_taken_s = prediction_valid & predicted_direction;

  // Resolution check against the FIFO head; resolves arriving in RECOVER belong to squashed work
  always_comb begin
    tag_err_s    = 1'b0;
    mispredict_s = 1'b0;
    if (res_valid && fetch_st_s) begin
      tag_err_s    = empty_s || (q_pc_r[rd_ptr_r] != res_pc);
      mispredict_s = tag_err_s
                  || (q_taken_r[rd_ptr_r] != res_direction)
                  || (res_direction && (q_tgt_r[rd_ptr_r] != res_target));
    end else begin
      tag_err_s    = 1'b0;
      mispredict_s = 1'b0;
    end
  end

  assign pop_s    = res_valid & ~empty_s & fetch_st_s;
  assign accept_s = imem_resp & ~stall & fetch_st_s
                  & ~(br_instr & full_s & ~pop_s) & ~mispredict_s;
  assign push_s   = accept_s & br_instr;

  // Next-state selection for the fetch/recover FSM
  always_comb begin
    state_nx_s = ST_FETCH;
    case (state_r)
      ST_FETCH:   state_nx_s = mispredict_s ? ST_RECOVER : ST_FETCH;
      ST_RECOVER: state_nx_s = ST_FETCH;
      default:    state_nx_s = ST_FETCH;
    endcase
  end

  // Control state: FSM, fetch PC, FIFO pointers, error flag and redirect counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      q_err_r  <= 1'b0;
      mp_cnt_r <= 16'h0000;
    end else begin
      state_r <= state_nx_s;
      if (mispredict_s) begin
        pc_r     <= res_direction ? res_target : (res_pc + 16'd2);
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        count_r  <= {(AW+1){1'b0}};
        q_err_r  <= q_err_r | tag_err_s;
        if (mp_cnt_r != 16'hFFFF) mp_cnt_r <= mp_cnt_r + 16'd1;
      end else begin
        if (accept_s) pc_r <= pred_taken_s ? predicted_target : (pc_r + 16'd2);
        if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
        if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + (AW+1)'(1);
          2'b01:   count_r <= count_r - (AW+1)'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Prediction storage; stale entries are never read because the count gates the head
  always_ff @(posedge clk) begin
    if (push_s && !mispredict_s) begin
      q_pc_r[wr_ptr_r]    <= pc_r;
      q_taken_r[wr_ptr_r] <= pred_taken_s;
      q_tgt_r[wr_ptr_r]   <= predicted_target;
    end
  end

  assign pc_out           = pc_r;
  assign imem_read        = fetch_st_s & ~reset;
  assign flush            = (state_r == ST_RECOVER);
  assign q_full           = full_s;
  assign q_err            = q_err_r;
  assign mispredict_count = mp_cnt_r;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: each task drives one scenario and checks
// outputs against hand-computed values.
module tb_fetch_redirect_unit;

  logic        clk = 1'b0;
  logic        reset, imem_resp, stall, br_instr, prediction_valid, predicted_direction;
  logic [15:0] predicted_target, res_pc, res_target;
  logic        res_valid, res_direction;
  logic [15:0] pc_out, mispredict_count;
  logic        imem_read, flush, q_full, q_err;

  int vectors = 0;
  int miscompares = 0;

  fetch_redirect_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .imem_resp(imem_resp), .stall(stall), .br_instr(br_instr),
    .prediction_valid(prediction_valid), .predicted_direction(predicted_direction),
    .predicted_target(predicted_target), .res_valid(res_valid), .res_pc(res_pc),
    .res_direction(res_direction), .res_target(res_target), .pc_out(pc_out),
    .imem_read(imem_read), .flush(flush), .q_full(q_full), .q_err(q_err),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic br, input logic pv, input logic pd, input logic [15:0] pt);
    br_instr = br; prediction_valid = pv; predicted_direction = pd; predicted_target = pt;
  endtask

  task automatic set_res(input logic v, input logic [15:0] pc, input logic d, input logic [15:0] t);
    res_valid = v; res_pc = pc; res_direction = d; res_target = t;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_resp = 1'b1; stall = 1'b0;
    set_fetch(1'b0, 1'b0, 1'b0, 16'h0000);
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    step();
    vectors++; if (pc_out !== 16'h0000) begin miscompares++; $display("FAIL rst_pc: pc_out=%h expected 0000", pc_out); end
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL rst_flush: flush=%b expected 0", flush); end
    vectors++; if (q_err !== 1'b0) begin miscompares++; $display("FAIL rst_qerr: q_err=%b expected 0", q_err); end
    vectors++; if (mispredict_count !== 16'h0000) begin miscompares++; $display("FAIL rst_cnt: count=%h expected 0000", mispredict_count); end
    vectors++; if (q_full !== 1'b0) begin miscompares++; $display("FAIL rst_full: q_full=%b expected 0", q_full); end
    vectors++; if (imem_read !== 1'b0) begin miscompares++; $display("FAIL rst_read: imem_read=%b expected 0", imem_read); end
    reset = 1'b0;
    #1;
    vectors++; if (imem_read !== 1'b1) begin miscompares++; $display("FAIL fetch_read: imem_read=%b expected 1", imem_read); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp_pc;
    exp_pc = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 16'd2;
      vectors++; if (pc_out !== exp_pc) begin miscompares++; $display("FAIL seq_pc: pc_out=%h expected %h", pc_out, exp_pc); end
      vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL seq_flush: flush=%b expected 0", flush); end
    end
    stall = 1'b1; step();
    vectors++; if (pc_out !== 16'h0006) begin miscompares++; $display("FAIL stall_hold: pc_out=%h expected 0006", pc_out); end
    stall = 1'b0; imem_resp = 1'b0; step();
    vectors++; if (pc_out !== 16'h0006) begin miscompares++; $display("FAIL noresp_hold: pc_out=%h expected 0006", pc_out); end
    imem_resp = 1'b1;
  endtask

  task automatic test_predict_hit();
    for (int i = 0; i < 5; i++) step();
    vectors++; if (pc_out !== 16'h0010) begin miscompares++; $display("FAIL hit_setup: pc_out=%h expected 0010", pc_out); end
    set_fetch(1'b1, 1'b1, 1'b1, 16'h0040); step();
    vectors++; if (pc_out !== 16'h0040) begin miscompares++; $display("FAIL hit_target: pc_out=%h expected 0040", pc_out); end
    set_fetch(1'b0, 1'b0, 1'b0, 16'h0000);
    set_res(1'b1, 16'h0010, 1'b1, 16'h0040); step();
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL hit_noflush: flush=%b expected 0", flush); end
    vectors++; if (pc_out !== 16'h0042) begin miscompares++; $display("FAIL hit_next: pc_out=%h expected 0042", pc_out); end
    vectors++; if (mispredict_count !== 16'h0000) begin miscompares++; $display("FAIL hit_cnt: count=%h expected 0000", mispredict_count); end
  endtask

  task automatic test_wrap();
    set_fetch(1'b1, 1'b1, 1'b1, 16'hFFFC); step();
    set_fetch(1'b0, 1'b0, 1'b0, 16'h0000);
    vectors++; if (pc_out !== 16'hFFFC) begin miscompares++; $display("FAIL wrap_tgt: pc_out=%h expected fffc", pc_out); end
    step(); step();
    vectors++; if (pc_out !== 16'h0000) begin miscompares++; $display("FAIL wrap_zero: pc_out=%h expected 0000", pc_out); end
    set_res(1'b1, 16'h0042, 1'b1, 16'hFFFC); step();
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    vectors++; if (pc_out !== 16'h0002 || flush !== 1'b0) begin miscompares++; $display("FAIL wrap_res: pc_out=%h flush=%b expected 0002/0", pc_out, flush); end
  endtask

  task automatic test_mispredict();
    for (int i = 0; i < 15; i++) step();
    vectors++; if (pc_out !== 16'h0020) begin miscompares++; $display("FAIL mp_setup: pc_out=%h expected 0020", pc_out); end
    set_fetch(1'b1, 1'b1, 1'b0, 16'h1234); step();
    set_fetch(1'b0, 1'b0, 1'b0, 16'h0000);
    vectors++; if (pc_out !== 16'h0022) begin miscompares++; $display("FAIL mp_nt: pc_out=%h expected 0022", pc_out); end
    set_res(1'b1, 16'h0020, 1'b1, 16'h0100); #1;
    vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL mp_preflush: flush=%b expected 0", flush); end
    step();
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL mp_flush: flush=%b expected 1", flush); end
    vectors++; if (pc_out !== 16'h0100) begin miscompares++; $display("FAIL mp_redirect: pc_out=%h expected 0100", pc_out); end
    vectors++; if (mispredict_count !== 16'h0001) begin miscompares++; $display("FAIL mp_cnt: count=%h expected 0001", mispredict_count); end
    vectors++; if (imem_read !== 1'b0) begin miscompares++; $display("FAIL mp_read: imem_read=%b expected 0", imem_read); end
    step();
    vectors++; if (flush !== 1'b0 || pc_out !== 16'h0100) begin miscompares++; $display("FAIL mp_recover: flush=%b pc_out=%h expected 0/0100", flush, pc_out); end
    step();
    vectors++; if (pc_out !== 16'h0102) begin miscompares++; $display("FAIL mp_resume: pc_out=%h expected 0102", pc_out); end
  endtask

  task automatic test_full();
    set_fetch(1'b1, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 4; i++) step();
    vectors++; if (q_full !== 1'b1 || pc_out !== 16'h010A) begin miscompares++; $display("FAIL full_fill: q_full=%b pc_out=%h expected 1/010a", q_full, pc_out); end
    step();
    vectors++; if (pc_out !== 16'h010A) begin miscompares++; $display("FAIL full_hold: pc_out=%h expected 010a", pc_out); end
    set_res(1'b1, 16'h0102, 1'b0, 16'h0000); step();
    vectors++; if (pc_out !== 16'h010C || q_full !== 1'b1) begin miscompares++; $display("FAIL full_pushpop: pc_out=%h q_full=%b expected 010c/1", pc_out, q_full); end
    set_fetch(1'b0, 1'b0, 1'b0, 16'h0000); imem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, 16'h0104 + 16'(2*i), 1'b0, 16'h0000); step();
      vectors++; if (q_full !== 1'b0 || flush !== 1'b0) begin miscompares++; $display("FAIL drain_%0d: q_full=%b flush=%b expected 0/0", i, q_full, flush); end
    end
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    vectors++; if (mispredict_count !== 16'h0001) begin miscompares++; $display("FAIL drain_cnt: count=%h expected 0001", mispredict_count); end
  endtask

  task automatic test_empty_resolve();
    set_res(1'b1, 16'h0030, 1'b0, 16'h0000); step();
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    vectors++; if (q_err !== 1'b1) begin miscompares++; $display("FAIL empty_qerr: q_err=%b expected 1", q_err); end
    vectors++; if (pc_out !== 16'h0032 || flush !== 1'b1) begin miscompares++; $display("FAIL empty_redirect: pc_out=%h flush=%b expected 0032/1", pc_out, flush); end
    vectors++; if (mispredict_count !== 16'h0002) begin miscompares++; $display("FAIL empty_cnt: count=%h expected 0002", mispredict_count); end
    step();
    vectors++; if (flush !== 1'b0 || q_err !== 1'b1) begin miscompares++; $display("FAIL empty_sticky: flush=%b q_err=%b expected 0/1", flush, q_err); end
  endtask

  task automatic test_reset_in_recover();
    set_res(1'b1, 16'h0050, 1'b0, 16'h0000); step();
    set_res(1'b0, 16'h0000, 1'b0, 16'h0000);
    vectors++; if (flush !== 1'b1 || pc_out !== 16'h0052) begin miscompares++; $display("FAIL rr_enter: flush=%b pc_out=%h expected 1/0052", flush, pc_out); end
    reset = 1'b1; imem_resp = 1'b1; step();
    vectors++; if (pc_out !== 16'h0000 || flush !== 1'b0) begin miscompares++; $display("FAIL rr_pc: pc_out=%h flush=%b expected 0000/0", pc_out, flush); end
    vectors++; if (mispredict_count !== 16'h0000 || q_err !== 1'b0) begin miscompares++; $display("FAIL rr_clear: count=%h q_err=%b expected 0000/0", mispredict_count, q_err); end
    reset = 1'b0; step();
    vectors++; if (pc_out !== 16'h0002) begin miscompares++; $display("FAIL rr_resume: pc_out=%h expected 0002", pc_out); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_predict_hit();
    test_wrap();
    test_mispredict();
    test_full();
    test_empty_resolve();
    test_reset_in_recover();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
